mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra memory cycles per access (0..7).
REQ-002 Parameter MAX_STREAK, default 4: consecutive CPU grants allowed while debug request pending (1..15).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  datapath access request; 1=write.
REQ-006 cpu_addr, cpu_wdata  input  16 each  datapath address/write data, stable while cpu_req high.
REQ-007 cpu_ready  output  1  one-cycle completion pulse for CPU access.
REQ-008 cpu_rdata  output  16  CPU read data, valid with cpu_ready, held until next CPU completion.
REQ-009 dbg_req, dbg_we  input  1 each; dbg_addr, dbg_wdata  input  16 each: debug/loader port, same rules as CPU.
REQ-010 dbg_ready  output  1; dbg_rdata  output  16: same rules as CPU.
REQ-011 mem_re, mem_we  output  1 each: memory strobes; mem_addr, mem_wdata  output  16 each; mem_rdata  input  16.
REQ-012 busy  output  1  high in any state other than IDLE; grant_dbg  output  1  high while debug owns the access.

Function
REQ-013 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any request is granted; ACCESS->DONE when wait count is 0; DONE->IDLE unconditionally.
REQ-014 Arbitration in IDLE: CPU wins unless dbg_req high and streak == MAX_STREAK; a lone requester always wins.
REQ-015 Streak counter increments on each CPU grant while dbg_req high, clears on any debug grant or CPU grant with dbg_req low, saturates at MAX_STREAK.
REQ-016 On grant, address, write data, we and owner are latched; mem_addr/mem_wdata driven from latches throughout ACCESS.
REQ-017 mem_re (read) or mem_we (write) held high for every ACCESS cycle (WAIT_STATES+1 cycles), low otherwise.
REQ-018 Wait counter loads WAIT_STATES on entry to ACCESS and decrements each ACCESS cycle; WAIT_STATES=0 gives one ACCESS cycle.
REQ-019 On the ACCESS->DONE edge, mem_rdata is captured into the owner's rdata register for reads; writes leave rdata unchanged.
REQ-020 In DONE, owner's ready high exactly one cycle; latency request-sampled-in-IDLE to ready = WAIT_STATES+2 cycles.
REQ-021 Requests are sampled only in IDLE; a request still high in the cycle after DONE is a new access.
REQ-022 Simultaneous requests in IDLE: loser keeps request pending, no drop, served at next IDLE per REQ-014.
REQ-023 Input changes during ACCESS/DONE have no effect on the current access.

Reset
REQ-024 reset forces IDLE, streak=0, wait counter=0, all strobes, ready and grant_dbg low, rdata registers 16'h0000, next cycle.
REQ-025 reset mid-access aborts it: no ready pulse issued; strobes low in the cycle after reset sampled.

Configuration
REQ-026 Macro MEM_ARB_DBG_PORT_EN: when defined, debug port and streak logic as above.
REQ-027 Without MEM_ARB_DBG_PORT_EN: dbg inputs ignored, dbg_ready=0, dbg_rdata=0, grant_dbg=0, CPU always wins; ports remain present.

Structure
REQ-028 Shared package mem_arb_pkg holds arb_state_t enum (IDLE, ACCESS, DONE), owner_t enum (OWN_CPU, OWN_DBG) and default WAIT_STATES/MAX_STREAK constants.
REQ-029 One sub-module arb_wait_counter: loadable 3-bit down-counter with load, enable and zero flag.

Verification
REQ-030 WAIT_STATES=1, cpu read 0x0040, mem_rdata=0xBEEF -> mem_re high 2 cycles, cpu_ready 3 cycles after request, cpu_rdata=0xBEEF.
REQ-031 WAIT_STATES=0, cpu write 0x0010<-0x1234 -> mem_we one cycle, mem_addr=0x0010, mem_wdata=0x1234, cpu_ready next cycle, cpu_rdata unchanged.
REQ-032 Both ports request continuously, MAX_STREAK=4 -> grant order CPU x4, DBG, CPU x4, DBG; no request lost.
REQ-033 reset asserted in second ACCESS cycle -> no ready pulse, strobes low next cycle, busy=0, rdata=0x0000.
REQ-034 Build without MEM_ARB_DBG_PORT_EN, dbg_req held high -> grant_dbg and dbg_ready never assert, CPU accesses unaffected.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default configuration for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned WAIT_W          = 3;
    localparam int unsigned STREAK_W        = 4;
    localparam int unsigned DEF_WAIT_STATES = 1;
    localparam int unsigned DEF_MAX_STREAK  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that times the memory wait states of one access.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic [WAIT_W-1:0] load_value,
    output logic              zero_c
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) single-memory arbiter with wait states.
// Debug port and fairness streak are built only with MEM_ARB_DBG_PORT_EN defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter int unsigned MAX_STREAK  = DEF_MAX_STREAK
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_dbg
);

    arb_state_t        state;
    arb_state_t        state_next;
    owner_t            owner;
    owner_t            owner_next;
    logic              lat_we;
    logic              grant_cpu_c;
    logic              grant_dbg_c;
    logic              grant_c;
    logic              dbg_win_c;
    logic              wait_zero_c;
    logic              done_c;
    logic              acc_we_c;
    logic              sel_we_c;
    logic [DATA_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

`ifdef MEM_ARB_DBG_PORT_EN
    logic [STREAK_W-1:0] streak;

    // Debug wins when alone, or once the CPU has used up its streak.
    assign dbg_win_c = dbg_req && (!cpu_req || (streak == STREAK_W'(MAX_STREAK)));

    always_ff @(posedge clock) begin
        if (reset) begin
            streak <= '0;
        end else if (grant_dbg_c) begin
            streak <= '0;
        end else if (grant_cpu_c) begin
            if (!dbg_req) begin
                streak <= '0;
            end else if (streak != STREAK_W'(MAX_STREAK)) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end
`else
    logic unused_dbg_req;

    assign unused_dbg_req = dbg_req;
    assign dbg_win_c      = 1'b0;
`endif

    // Next-state and grant decode; requests are only looked at in IDLE.
    always_comb begin
        state_next  = state;
        grant_cpu_c = 1'b0;
        grant_dbg_c = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_win_c) begin
                    grant_dbg_c = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu_c = 1'b1;
                end
                if (grant_dbg_c || grant_cpu_c) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_zero_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_c     = grant_cpu_c || grant_dbg_c;
        done_c      = (state == ACCESS) && wait_zero_c;
        sel_we_c    = grant_dbg_c ? dbg_we    : cpu_we;
        sel_addr_c  = grant_dbg_c ? dbg_addr  : cpu_addr;
        sel_wdata_c = grant_dbg_c ? dbg_wdata : cpu_wdata;
        acc_we_c    = grant_c ? sel_we_c : lat_we;
        owner_next  = owner;
        if (grant_dbg_c) begin
            owner_next = OWN_DBG;
        end else if (grant_cpu_c) begin
            owner_next = OWN_CPU;
        end
    end

    arb_wait_counter u_wait (
        .clock      (clock),
        .reset      (reset),
        .load       (grant_c),
        .enable     (state == ACCESS),
        .load_value (WAIT_W'(WAIT_STATES)),
        .zero_c     (wait_zero_c)
    );

    // State register plus registered strobes, handshakes and read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            grant_dbg <= 1'b0;
            cpu_ready <= 1'b0;
            dbg_ready <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            if (grant_c) begin
                lat_we    <= sel_we_c;
                mem_addr  <= sel_addr_c;
                mem_wdata <= sel_wdata_c;
            end
            mem_re    <= (state_next == ACCESS) && !acc_we_c;
            mem_we    <= (state_next == ACCESS) && acc_we_c;
            busy      <= (state_next != IDLE);
            grant_dbg <= (state_next != IDLE) && (owner_next == OWN_DBG);
            cpu_ready <= done_c && (owner == OWN_CPU);
            dbg_ready <= done_c && (owner == OWN_DBG);
            if (done_c && !lat_we) begin
                if (owner == OWN_DBG) begin
                    dbg_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
